// File: rtl/ahb_pkg.sv
// Shared AHB types and helpers for the bus arbiter slice.
package ahb_pkg;

    localparam int BEATS_W = 4;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_BUSY   = 2'b01,
        HT_NONSEQ = 2'b10,
        HT_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HB_SINGLE = 3'b000,
        HB_INCR   = 3'b001,
        HB_WRAP4  = 3'b010,
        HB_INCR4  = 3'b011,
        HB_WRAP8  = 3'b100,
        HB_INCR8  = 3'b101,
        HB_WRAP16 = 3'b110,
        HB_INCR16 = 3'b111
    } hburst_t;

    typedef enum logic [1:0] {
        ST_ARB    = 2'b00,
        ST_BURST  = 2'b01,
        ST_LOCKED = 2'b10
    } arb_state_t;

    // Number of beats in a burst; 0 marks the undefined-length INCR burst.
    function automatic logic [4:0] burst_len(input hburst_t burst);
        logic [4:0] len;
        case (burst)
            HB_SINGLE:           len = 5'd1;
            HB_INCR:             len = 5'd0;
            HB_WRAP4, HB_INCR4:  len = 5'd4;
            HB_WRAP8, HB_INCR8:  len = 5'd8;
            HB_WRAP16, HB_INCR16: len = 5'd16;
            default:             len = 5'd1;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/ahb_arbiter_chk.sv
// Structural checks on the arbiter outputs: one-hot grant, valid Hmaster.
module ahb_arbiter_chk #(
    parameter int NUM_MASTERS = 4
) (
    input logic                           Hclk,
    input logic                           Hresetn,
    input logic [NUM_MASTERS-1:0]         Hgrant_M,
    input logic [$clog2(NUM_MASTERS)-1:0] Hmaster
);

    // Grant must be exactly one-hot and Hmaster must name a real master.
    always @(posedge Hclk) begin
        if (Hresetn) begin
            assert ($onehot(Hgrant_M))
                else $error("chk grant not one-hot: %b", Hgrant_M);
            assert (32'(Hmaster) < 32'(NUM_MASTERS))
                else $error("chk Hmaster out of range: %0d", Hmaster);
        end
    end

endmodule

// File: rtl/ahb_rr_picker.sv
// Combinational round-robin picker: first requester after rr_ptr wins,
// with rr_ptr itself considered last so a lone owner keeps the bus.
module ahb_rr_picker
    import ahb_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int IW          = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IW-1:0]          rr_ptr,
    output logic [NUM_MASTERS-1:0] pick,
    output logic [IW-1:0]          pick_idx,
    output logic                   any_req
);

    localparam logic [NUM_MASTERS-1:0] ONE_HOT0 = {{(NUM_MASTERS-1){1'b0}}, 1'b1};

    logic [IW-1:0] scan_idx_s;
    logic          hit_s;
    logic          found_s;

    // Rotating priority scan starting one past the last granted master.
    always_comb begin
        scan_idx_s = '0;
        hit_s      = 1'b0;
        found_s    = 1'b0;
        pick_idx   = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            scan_idx_s = IW'((int'(rr_ptr) + i) % NUM_MASTERS);
            hit_s      = !found_s && req[scan_idx_s];
            pick_idx   = hit_s ? scan_idx_s : pick_idx;
            found_s    = found_s | hit_s;
        end
        any_req = found_s;
        pick    = found_s ? (ONE_HOT0 << pick_idx) : '0;
    end

endmodule

// File: rtl/ahb_arbiter.sv
// AHB bus arbiter: round-robin grant with default master, ownership held
// across fixed-length bursts and locked sequences, Hmaster trailing Hgrant_M
// by one Hready-qualified edge.
module ahb_arbiter
    import ahb_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int DEF_MASTER  = 0
) (
    input  logic                           Hclk,
    input  logic                           Hresetn,
    input  logic [NUM_MASTERS-1:0]         Hbusreq_M,
    input  logic [NUM_MASTERS-1:0]         Hlock_M,
    input  logic [1:0]                     Htrans,
    input  logic [2:0]                     Hburst,
    input  logic                           Hready,
    output logic [NUM_MASTERS-1:0]         Hgrant_M,
    output logic [$clog2(NUM_MASTERS)-1:0] Hmaster,
    output logic                           Hmastlock
);

    localparam int IW = $clog2(NUM_MASTERS);
    localparam logic [NUM_MASTERS-1:0] DEF_ONEHOT =
        {{(NUM_MASTERS-1){1'b0}}, 1'b1} << DEF_MASTER;
    localparam logic [IW-1:0] DEF_IDX = IW'(DEF_MASTER);

    arb_state_t             state_r,       state_s;
    logic [BEATS_W-1:0]     beats_r,       beats_s;
    logic [IW-1:0]          rr_ptr_r,      rr_ptr_s;
    logic [NUM_MASTERS-1:0] grant_r,       grant_s;
    logic                   unlock_pend_r, unlock_pend_s;
    logic [IW-1:0]          hmaster_r;
    logic                   hmastlock_r;

    htrans_t                trans_s;
    logic [4:0]             len_s;
    logic                   fixed_s;
    logic [BEATS_W-1:0]     len_m1_s;
    logic [BEATS_W-1:0]     beat_count_s;
    logic [IW-1:0]          grant_idx_s;
    logic                   lock_own_s;
    logic                   rearb_s;

    logic [NUM_MASTERS-1:0] pick_s;
    logic [IW-1:0]          pick_idx_s;
    logic                   any_req_s;

    ahb_rr_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .IW          (IW)
    ) u_picker (
        .req      (Hbusreq_M),
        .rr_ptr   (rr_ptr_r),
        .pick     (pick_s),
        .pick_idx (pick_idx_s),
        .any_req  (any_req_s)
    );

    // Decode the current transfer and the grant owner's index and lock request.
    always_comb begin
        trans_s     = htrans_t'(Htrans);
        len_s       = burst_len(hburst_t'(Hburst));
        fixed_s     = (len_s > 5'd1);
        len_m1_s    = len_s[BEATS_W-1:0] - 4'd1;
        grant_idx_s = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            grant_idx_s = grant_idx_s | ({IW{grant_r[i]}} & IW'(i));
        end
        lock_own_s = Hlock_M[grant_idx_s];
    end

    // Beat counter as it evolves on an accepted transfer, independent of state.
    always_comb begin
        beat_count_s = beats_r;
        case (trans_s)
            HT_NONSEQ: beat_count_s = fixed_s ? len_m1_s : 4'd0;
            HT_IDLE:   beat_count_s = 4'd0;
            HT_SEQ:    beat_count_s = (beats_r != 4'd0) ? (beats_r - 4'd1) : 4'd0;
            HT_BUSY:   beat_count_s = beats_r;
            default:   beat_count_s = beats_r;
        endcase
    end

    // Next-state, beat counter and grant decision; nothing moves while Hready=0.
    always_comb begin
        state_s       = state_r;
        beats_s       = beats_r;
        rr_ptr_s      = rr_ptr_r;
        grant_s       = grant_r;
        unlock_pend_s = unlock_pend_r;
        rearb_s       = 1'b0;
        if (Hready) begin
            case (state_r)
                ST_ARB: begin
                    if (lock_own_s) begin
                        state_s = ST_LOCKED;
                        beats_s = beat_count_s;
                    end else if (trans_s == HT_NONSEQ && fixed_s) begin
                        state_s = ST_BURST;
                        beats_s = len_m1_s;
                    end else begin
                        beats_s = 4'd0;
                        rearb_s = 1'b1;
                    end
                end
                ST_BURST: begin
                    if (lock_own_s) begin
                        state_s = ST_LOCKED;
                        beats_s = beat_count_s;
                    end else if (trans_s == HT_IDLE || trans_s == HT_NONSEQ) begin
                        // early termination hands the bus back
                        state_s = ST_ARB;
                        beats_s = 4'd0;
                        rearb_s = 1'b1;
                    end else if (trans_s == HT_SEQ && beats_r <= 4'd1) begin
                        state_s = ST_ARB;
                        beats_s = 4'd0;
                        rearb_s = 1'b1;
                    end else begin
                        beats_s = beat_count_s;
                    end
                end
                ST_LOCKED: begin
                    beats_s = beat_count_s;
                    if (lock_own_s) begin
                        unlock_pend_s = 1'b0;
                    end else if (!unlock_pend_r) begin
                        // lock dropped: grant one more accepted transfer
                        unlock_pend_s = 1'b1;
                    end else begin
                        unlock_pend_s = 1'b0;
                        if (beat_count_s != 4'd0) begin
                            state_s = ST_BURST;
                        end else begin
                            state_s = ST_ARB;
                            rearb_s = 1'b1;
                        end
                    end
                end
                default: begin
                    state_s       = ST_ARB;
                    beats_s       = 4'd0;
                    unlock_pend_s = 1'b0;
                end
            endcase
            if (rearb_s) begin
                if (any_req_s) begin
                    grant_s  = pick_s;
                    rr_ptr_s = pick_idx_s;
                end else begin
                    grant_s  = DEF_ONEHOT;
                end
            end else begin
                grant_s = grant_r;
            end
        end else begin
            state_s = state_r;
        end
    end

    // Arbiter state, counter, pointer and grant registers.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_r       <= ST_ARB;
            beats_r       <= 4'd0;
            rr_ptr_r      <= DEF_IDX;
            grant_r       <= DEF_ONEHOT;
            unlock_pend_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            beats_r       <= beats_s;
            rr_ptr_r      <= rr_ptr_s;
            grant_r       <= grant_s;
            unlock_pend_r <= unlock_pend_s;
        end
    end

    // Address-phase owner follows the grant on each Hready-qualified edge.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            hmaster_r   <= DEF_IDX;
            hmastlock_r <= 1'b0;
        end else if (Hready) begin
            hmaster_r   <= grant_idx_s;
            hmastlock_r <= lock_own_s;
        end else begin
            hmaster_r   <= hmaster_r;
            hmastlock_r <= hmastlock_r;
        end
    end

    assign Hgrant_M  = grant_r;
    assign Hmaster   = hmaster_r;
    assign Hmastlock = hmastlock_r;

endmodule
